// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared defaults and operation encoding for the lfsr block
package lfsr_pkg;

  localparam int         LFSR_WIDTH_DEFAULT = 8;
  localparam logic [7:0] TAPS_DEFAULT       = 8'b10101010;

  // What the shift register does on the next rising edge
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_STEP  = 2'd1,
    OP_SHIFT = 2'd2
  } lfsr_op_e;

endpackage

// File: rtl/lfsr_serializer.sv
// rtl/lfsr_serializer.sv - LSB-first read-out sequencing: bit counter, out and valid
module lfsr_serializer #(
  parameter int LFSR_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic out_enable,
  input  logic lsb,
  output logic shift,
  output logic out,
  output logic valid
);

  localparam int CNT_W = $clog2(LFSR_WIDTH) + 1;

  logic [CNT_W-1:0] bit_cnt;

  // Stepping wins over read-out; once every bit has gone out, stay quiet until re-armed
  assign shift = !enable && out_enable && (bit_cnt < CNT_W'(LFSR_WIDTH));

  // Register the outgoing bit and count it; any other cycle drives valid/out low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
    end else if (enable) begin
      bit_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
    end else if (shift) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      out     <= lsb;
      valid   <= 1'b1;
    end else begin
      out     <= 1'b0;
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr.sv
// rtl/lfsr.sv - Galois-style LFSR with serial read-out; optional macro LFSR_ZERO_SEED_GUARD_EN
module lfsr
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH = LFSR_WIDTH_DEFAULT,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(TAPS_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  enable,
  input  logic                  out_enable,
  output logic                  out,
  output logic                  valid
);

  logic [LFSR_WIDTH-1:0] lfsr_reg;
  logic [LFSR_WIDTH-1:0] step_next;
  logic [LFSR_WIDTH-1:0] seed_load;
  logic                  shift;
  lfsr_op_e              op;

`ifdef LFSR_ZERO_SEED_GUARD_EN
  // An all-zero seed would lock the register at zero forever, so force the LSB on
  assign seed_load = (seed == '0) ? LFSR_WIDTH'(1) : seed;
`else
  assign seed_load = seed;
`endif

  // One feedback step: MSB wraps into bit 0 and is XORed into every tapped stage
  always_comb begin
    step_next    = '0;
    step_next[0] = lfsr_reg[LFSR_WIDTH-1];
    for (int i = 1; i < LFSR_WIDTH; i++) begin
      step_next[i] = lfsr_reg[i-1] ^ (TAPS[i] & lfsr_reg[LFSR_WIDTH-1]);
    end
  end

  // Choose this cycle's register operation; enable has priority over read-out
  always_comb begin
    op = OP_HOLD;
    if (enable) begin
      op = OP_STEP;
    end else if (shift) begin
      op = OP_SHIFT;
    end
  end

  // Register update; seed is only sampled while reset is asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= seed_load;
    end else begin
      case (op)
        OP_STEP:  lfsr_reg <= step_next;
        OP_SHIFT: lfsr_reg <= {1'b0, lfsr_reg[LFSR_WIDTH-1:1]};
        default:  lfsr_reg <= lfsr_reg;
      endcase
    end
  end

  lfsr_serializer #(
    .LFSR_WIDTH (LFSR_WIDTH)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .out_enable (out_enable),
    .lsb        (lfsr_reg[0]),
    .shift      (shift),
    .out        (out),
    .valid      (valid)
  );

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - self-checking scoreboard bench for lfsr
module tb_lfsr;

  localparam logic [7:0] TB_TAPS = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seed = 8'h93;
  logic       enable = 1'b0;
  logic       out_enable = 1'b0;
  logic       out;
  logic       valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];
  bit obs_q[$];

  lfsr dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .enable     (enable),
    .out_enable (out_enable),
    .out        (out),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_steps(input logic [7:0] s, input int n);
    logic [7:0] r;
    logic [7:0] nx;
    r = s;
    for (int k = 0; k < n; k++) begin
      nx[0] = r[7];
      for (int i = 1; i < 8; i++) nx[i] = r[i-1] ^ (TB_TAPS[i] & r[7]);
      r = nx;
    end
    return r;
  endfunction

  function automatic logic [7:0] seed_eff(input logic [7:0] s);
`ifdef LFSR_ZERO_SEED_GUARD_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
  endtask

  task automatic do_reset(input logic [7:0] s);
    @(negedge clk);
    rst = 1'b1; seed = s; enable = 1'b0; out_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_enable(input int n);
    enable = 1'b1;
    repeat (n) @(negedge clk);
    enable = 1'b0;
  endtask

  // Collects every bit the DUT flags valid over n cycles into obs_q
  task automatic run_readout(input int n);
    enable = 1'b0;
    out_enable = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) obs_q.push_back(out);
    end
    out_enable = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; seed = 8'h93;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || out !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: valid=%b out=%b, required 0 0", valid, out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_readout_seed;
    int n;
    do_reset(8'h93);
    push_word(8'h93);
    run_readout(14);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL seed_readout_len: got %0d valid bits, required 8", obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL seed_readout bit%0d: got %b, required %b", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_step_one;
    int n;
    do_reset(8'h93);
    do_enable(1);
    push_word(8'h8D);
    run_readout(10);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL step_one_len: got %0d valid bits, required 8", obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL step_one bit%0d: got %b, required %b", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_multi_step;
    logic [7:0] seeds [5];
    seeds = '{8'h93, 8'h01, 8'hFF, 8'h5A, 8'hC3};
    for (int s = 0; s < 5; s++) begin
      int n;
      do_reset(seeds[s]);
      do_enable(10);
      push_word(model_steps(seeds[s], 10));
      run_readout(10);
      n_cmp++;
      if (obs_q.size() != 8) begin
        n_bad++; $display("FAIL multi_step_len seed=%h: got %0d, required 8", seeds[s], obs_q.size());
      end
      n = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        bit e, o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL multi_step seed=%h bit%0d: got %b, required %b", seeds[s], n, o, e);
        end
        n++;
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_both_high;
    int n;
    do_reset(8'h93);
    enable = 1'b1; out_enable = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL both_high_valid: got %b, required 0", valid); end
    end
    enable = 1'b0; out_enable = 1'b0;
    push_word(model_steps(8'h93, 3));
    run_readout(10);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL both_high_len: got %0d, required 8", obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL both_high bit%0d: got %b, required %b", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_pause;
    int n;
    do_reset(8'hB6);
    push_word(8'hB6);
    run_readout(3);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL pause_valid: got %b, required 0", valid); end
    end
    run_readout(10);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL pause_len: got %0d, required 8", obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL pause bit%0d: got %b, required %b", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset(8'h93);
    run_readout(4);
    obs_q.delete();
    out_enable = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || out !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_async: valid=%b out=%b, required 0 0", valid, out);
    end
    @(negedge clk);
    out_enable = 1'b0;
    rst = 1'b0;
    push_word(8'h93);
    run_readout(10);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL reset_mid_len: got %0d, required 8", obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_mid bit%0d: got %b, required %b", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_seed_change;
    int n;
    do_reset(8'h93);
    seed = 8'h4E;
    repeat (3) @(negedge clk);
    push_word(8'h93);
    run_readout(10);
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL seed_change_len: got %0d, required 8", obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      bit e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL seed_change bit%0d: got %b, required %b", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_zero_seed;
    for (int pass = 0; pass < 2; pass++) begin
      int n;
      do_reset(8'h00);
      if (pass == 1) do_enable(5);
      push_word(model_steps(seed_eff(8'h00), (pass == 1) ? 5 : 0));
      run_readout(10);
      n_cmp++;
      if (obs_q.size() != 8) begin
        n_bad++; $display("FAIL zero_seed_len pass%0d: got %0d, required 8", pass, obs_q.size());
      end
      n = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        bit e, o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin
          n_bad++; $display("FAIL zero_seed pass%0d bit%0d: got %b, required %b", pass, n, o, e);
        end
        n++;
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_readout_seed();
    test_step_one();
    test_multi_step();
    test_both_high();
    test_pause();
    test_reset_mid();
    test_seed_change();
    test_zero_seed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
